// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter sequencing controller.
package counter_ctrl_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_REP_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ctr_datapath.sv
// Up-counter that wraps to zero after reaching an inclusive limit.
module ctr_datapath #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             at_limit
);

   assign at_limit = (cnt == limit);

   // Compare before increment, so a full-range limit wraps without overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= at_limit ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer: runs the counter 0..limit for a number of passes,
// with pause/abort, per-wrap tick and a completion pulse.
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_limit,
   input  logic [REP_W-1:0] cmd_reps,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] cnt,
   output logic [REP_W-1:0] rep_left,
   output logic             busy,
   output logic             tick,
   output logic             done
);

   state_t           state;
   logic [WIDTH-1:0] limit_q;
   logic             clr;
   logic             en;
   logic             at_limit;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Counter steering mirrors the FSM priority: abort, then pause, then count.
   always_comb begin
      clr = 1'b0;
      en  = 1'b0;
      case (state)
         IDLE:    clr = cmd_valid;
         RUN: begin
            if (abort)      clr = 1'b1;
            else if (!pause) en = 1'b1;
         end
         PAUSE:   clr = abort;
         default: ;
      endcase
   end

   ctr_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (en),
      .limit    (limit_q),
      .cnt      (cnt),
      .at_limit (at_limit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         limit_q  <= '0;
         rep_left <= '0;
         tick     <= 1'b0;
         done     <= 1'b0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_reps != '0) begin
                     limit_q  <= cmd_limit;
                     rep_left <= cmd_reps;
                     state    <= RUN;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state    <= IDLE;
                  rep_left <= '0;
               end else if (pause) begin
                  state <= PAUSE;
               end else if (at_limit) begin
                  rep_left <= rep_left - 1'b1;
                  tick     <= 1'b1;
                  if (rep_left == REP_W'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (abort) begin
                  state    <= IDLE;
                  rep_left <= '0;
               end else if (!pause) begin
                  state <= RUN;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a queue of expected post-edge outputs.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_limit;
   logic [3:0] cmd_reps;
   logic       pause;
   logic       abort;
   logic [3:0] cnt;
   logic [3:0] rep_left;
   logic       busy;
   logic       tick;
   logic       done;

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_limit (cmd_limit),
      .cmd_reps  (cmd_reps),
      .pause     (pause),
      .abort     (abort),
      .cnt       (cnt),
      .rep_left  (rep_left),
      .busy      (busy),
      .tick      (tick),
      .done      (done)
   );

   typedef struct {
      logic [3:0] cnt;
      logic [3:0] rep;
      logic       tick;
      logic       done;
      logic       busy;
      logic       ready;
   } exp_t;

   exp_t  q[$];
   int    n_chk = 0;
   int    n_err = 0;
   string phase = "init";

   task automatic push_e(input int c, input int r, input bit t, input bit d,
                         input bit b, input bit rd);
      exp_t e;
      e.cnt = c[3:0]; e.rep = r[3:0];
      e.tick = t; e.done = d; e.busy = b; e.ready = rd;
      q.push_back(e);
   endtask

   task automatic push_idle();
      push_e(0, 0, 0, 0, 0, 1);
   endtask

   // Expected outputs after each edge of an unpaused run, from the edge after
   // acceptance through the edge that enters DONE.
   task automatic push_run(input int lim, input int reps);
      for (int r = reps; r >= 1; r--)
         for (int k = 1; k <= lim + 1; k++) begin
            bit wrap;
            wrap = (k == lim + 1);
            push_e(wrap ? 0 : k, wrap ? r - 1 : r, wrap, wrap && (r == 1), 1, 0);
         end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s.%s observed=%0d expected=%0d", phase, tag, obs, expv);
      end
   endtask

   task automatic sample();
      exp_t e;
      n_chk++;
      assert (q.size() != 0) else begin
         n_err++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", phase);
      end
      if (q.size() == 0) return;
      e = q.pop_front();
      chk("cnt",       32'(cnt),      32'(e.cnt));
      chk("rep_left",  32'(rep_left), 32'(e.rep));
      chk("tick",      32'(tick),     32'(e.tick));
      chk("done",      32'(done),     32'(e.done));
      chk("busy",      32'(busy),     32'(e.busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic accept(input int lim, input int reps);
      cmd_valid = 1'b1;
      cmd_limit = lim[3:0];
      cmd_reps  = reps[3:0];
      push_e(0, reps, 0, 0, 1, 0);
      step();
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_limit = '0; cmd_reps = '0;
      pause = 1'b0; abort = 1'b0;

      // 1: reset values, then quiet idle (abort must be ignored in IDLE)
      phase = "reset";
      #1;
      push_idle(); sample();
      #19 rst = 1'b0;
      phase = "idle";
      for (int i = 0; i < 10; i++) push_idle();
      abort = 1'b1;
      steps(3);
      abort = 1'b0;
      steps(7);

      // 2: limit=3 reps=2
      phase = "basic";
      accept(3, 2);
      push_run(3, 2);
      push_idle();
      steps(9);

      // 3: pause at cnt=2 for three edges, limit=5 reps=1
      phase = "pause";
      accept(5, 1);
      push_e(1, 1, 0, 0, 1, 0);
      push_e(2, 1, 0, 0, 1, 0);
      steps(2);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) push_e(2, 1, 0, 0, 1, 0);
      steps(3);
      pause = 1'b0;
      push_e(2, 1, 0, 0, 1, 0);
      push_e(3, 1, 0, 0, 1, 0);
      push_e(4, 1, 0, 0, 1, 0);
      push_e(5, 1, 0, 0, 1, 0);
      push_e(0, 0, 1, 1, 1, 0);
      push_idle();
      steps(6);

      // 4: abort at cnt=4 rep_left=2, limit=7 reps=3
      phase = "abort";
      accept(7, 3);
      for (int k = 1; k <= 7; k++) push_e(k, 3, 0, 0, 1, 0);
      push_e(0, 2, 1, 0, 1, 0);
      for (int k = 1; k <= 4; k++) push_e(k, 2, 0, 0, 1, 0);
      steps(12);
      abort = 1'b1;
      push_idle();
      step();
      abort = 1'b0;
      push_idle(); push_idle();
      steps(2);

      // 5a: reps=0 completes at once without counting
      phase = "reps0";
      cmd_valid = 1'b1; cmd_limit = 4'd5; cmd_reps = 4'd0;
      push_e(0, 0, 0, 1, 1, 0);
      step();
      cmd_valid = 1'b0;
      push_idle(); push_idle();
      steps(2);

      // 5b: limit=0 reps=4 ticks every RUN cycle
      phase = "limit0";
      accept(0, 4);
      push_run(0, 4);
      push_idle();
      steps(5);

      // 5c: cmd_valid held through RUN and DONE is only taken in IDLE
      phase = "held";
      cmd_valid = 1'b1; cmd_limit = 4'd2; cmd_reps = 4'd1;
      push_e(0, 1, 0, 0, 1, 0);
      step();
      cmd_limit = 4'd9; cmd_reps = 4'd5;
      push_run(2, 1);
      push_idle();
      push_e(0, 5, 0, 0, 1, 0);
      steps(5);
      cmd_valid = 1'b0;
      abort = 1'b1;
      push_idle();
      step();
      abort = 1'b0;

      // 5d: full-range limit wraps cleanly
      phase = "limit15";
      accept(15, 1);
      push_run(15, 1);
      push_idle();
      steps(17);

      // 6: asynchronous reset between edges at cnt=6
      phase = "async_rst";
      accept(9, 2);
      for (int k = 1; k <= 6; k++) push_e(k, 2, 0, 0, 1, 0);
      steps(6);
      #2 rst = 1'b1;
      #1;
      push_idle(); sample();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) push_idle();
      steps(4);

      phase = "end";
      n_chk++;
      assert (q.size() == 0) else begin
         n_err++;
         $error("FAIL end.scoreboard observed=%0d expected=0 leftover entries", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
